// File: rtl/pio_tx_pkg.sv
// Shared types and helpers for the PIO TX weighted round-robin arbiter.
package pio_tx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } pio_state_e;

  localparam int MAX_N = 32;

  // Returns 1 when the vector holds an odd number of ones (zero padding is harmless).
  function automatic logic odd_par(input logic [63:0] v);
    return ^v;
  endfunction

  function automatic logic [4:0] onehot2bin(input logic [MAX_N-1:0] oh);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) b = b | 5'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/pio_tx_rrb_pick.sv
// Combinational round-robin pick: lowest requester above the pointer, else lowest overall.
module pio_tx_rrb_pick
  import pio_tx_pkg::*;
#(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  pointer,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic [N-1:0]  nxt_ptr,
  output logic          nxt_ptr_p
);

  localparam logic NM1_ODD = 1'((N - 1) % 2);

  logic [N-1:0] cand;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  always_comb begin
    cand    = req & ~excl;
    masked  = cand & pointer;
    src     = (|masked) ? masked : cand;
    win     = src & (~src + N'(1));
    any     = |cand;
    idx     = IW'(onehot2bin(MAX_N'(win)));
    nxt_ptr = ~(win | (win - N'(1)));
    // The mask above idx holds N-1-idx ones; choose p so the total is odd.
    nxt_ptr_p = ~(NM1_ODD ^ idx[0]);
  end

endmodule

// File: rtl/pio_tx_wrrb.sv
// Weighted round-robin arbiter for the PIO TX path with parity-protected
// pointer/credit state and a sticky parity-error flag.
module pio_tx_wrrb
  import pio_tx_pkg::*;
#(
  parameter int N  = 6,
  parameter int CW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          user_clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N*CW-1:0] weight,
  output logic [N-1:0]  tkn,
  output logic [IW-1:0] tkn_id,
  output logic          tkn_vld,
  input  logic          tkn_ack,
  output logic          pe,
  output pio_state_e    fsm_state
);

  // Handshake: a requester raises req and holds it until its tkn is seen
  // together with tkn_ack in the same cycle; each such cycle is one transfer.
  // tkn_ack is ignored while no token is out.

  localparam logic PTR_RST_P = 1'((N + 1) % 2);

  pio_state_e     state;
  logic [N-1:0]   pointer_reg;
  logic           pointer_p;
  logic [CW-1:0]  credit;
  logic           credit_p;

  logic           credit_zero;
  logic           hold_grant;
  logic           rel_grant;
  logic           do_pick;
  logic [N-1:0]   excl;
  logic [N-1:0]   pk_win;
  logic [IW-1:0]  pk_idx;
  logic           pk_any;
  logic [N-1:0]   pk_nxt_ptr;
  logic           pk_nxt_ptr_p;
  logic [CW-1:0]  wsel;
  logic [CW-1:0]  credit_load;
  logic [CW-1:0]  credit_dec;
  logic           par_err;

  always_comb begin
    credit_zero = (credit == '0);
    hold_grant  = (state == GRANT) && tkn_ack && !credit_zero && req[tkn_id];
    rel_grant   = (state == GRANT) && tkn_ack && !hold_grant;
    do_pick     = (state == IDLE) || rel_grant;
    excl        = (rel_grant && credit_zero) ? tkn : '0;
    wsel        = weight[pk_idx*CW +: CW];
    credit_load = (wsel == '0) ? '0 : wsel - CW'(1);
    credit_dec  = credit - CW'(1);
    par_err     = !odd_par(64'({pointer_reg, pointer_p})) ||
                  !odd_par(64'({credit, credit_p}));
  end

  pio_tx_rrb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req       (req),
    .pointer   (pointer_reg),
    .excl      (excl),
    .win       (pk_win),
    .idx       (pk_idx),
    .any       (pk_any),
    .nxt_ptr   (pk_nxt_ptr),
    .nxt_ptr_p (pk_nxt_ptr_p)
  );

  // The pointer is loaded with "mask above winner" when the grant is issued,
  // so by the time that grant is released it already equals "mask above cur".
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state       <= IDLE;
      tkn         <= '0;
      tkn_id      <= '0;
      pointer_reg <= '1;
      pointer_p   <= PTR_RST_P;
      credit      <= '0;
      credit_p    <= 1'b1;
      pe          <= 1'b0;
    end else begin
      pe <= pe | par_err;
      if (do_pick) begin
        if (pk_any) begin
          state       <= GRANT;
          tkn         <= pk_win;
          tkn_id      <= pk_idx;
          credit      <= credit_load;
          credit_p    <= ~^credit_load;
          pointer_reg <= pk_nxt_ptr;
          pointer_p   <= pk_nxt_ptr_p;
        end else begin
          state  <= IDLE;
          tkn    <= '0;
          tkn_id <= '0;
        end
      end else if (hold_grant) begin
        credit   <= credit_dec;
        credit_p <= ~^credit_dec;
      end
    end
  end

  assign tkn_vld   = |tkn;
  assign fsm_state = state;

endmodule

// File: tb/tb_pio_tx_wrrb.sv
// Bench for pio_tx_wrrb: directed vector table, corner sequences and a
// randomized run against an abstract arbitration model.
module tb_pio_tx_wrrb;
  import pio_tx_pkg::*;

  localparam int N  = 6;
  localparam int CW = 4;
  localparam int IW = 3;

  logic            user_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] weight;
  logic [N-1:0]    tkn;
  logic [IW-1:0]   tkn_id;
  logic            tkn_vld;
  logic            tkn_ack;
  logic            pe;
  pio_state_e      fsm_state;

  pio_tx_wrrb #(.N(N), .CW(CW), .IW(IW)) dut (
    .user_clk  (user_clk),
    .reset     (reset),
    .req       (req),
    .weight    (weight),
    .tkn       (tkn),
    .tkn_id    (tkn_id),
    .tkn_vld   (tkn_vld),
    .tkn_ack   (tkn_ack),
    .pe        (pe),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*CW-1:0] mkwt(input int w0, input int w2);
    logic [N*CW-1:0] f;
    for (int i = 0; i < N; i++) f[i*CW +: CW] = CW'(1);
    f[0 +: CW]    = CW'(w0);
    f[2*CW +: CW] = CW'(w2);
    return f;
  endfunction

  // vector table
  typedef struct {
    logic            rst;
    logic [N-1:0]    req;
    logic            ack;
    logic [N*CW-1:0] wt;
    logic [N-1:0]    exp_tkn;
  } vec_t;

  vec_t            vecs[$];
  logic [N*CW-1:0] cur_wt;

  task automatic add(input logic r, input logic [N-1:0] rq, input logic a, input logic [N-1:0] e);
    vec_t v;
    v.rst = r; v.req = rq; v.ack = a; v.wt = cur_wt; v.exp_tkn = e;
    vecs.push_back(v);
  endtask

  // reference model: grant holder, remaining burst, last released index
  int m_busy, m_cur, m_left, m_last;

  function automatic int m_pick(input logic [N-1:0] r, input int after, input int ex);
    for (int i = after + 1; i < N; i++) if (r[i] && i != ex) return i;
    for (int i = 0; i < N; i++) if (r[i] && i != ex) return i;
    return -1;
  endfunction

  function automatic int eff_w(input logic [N*CW-1:0] w, input int i);
    int v;
    v = int'(w[i*CW +: CW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic a,
                            input logic [N*CW-1:0] w);
    int p;
    if (r) begin
      m_busy = 0;
      m_last = -1;
    end else if (m_busy == 0) begin
      p = m_pick(rq, m_last, -1);
      if (p >= 0) begin
        m_busy = 1; m_cur = p; m_left = eff_w(w, p);
      end
    end else if (a) begin
      m_left--;
      if (!(m_left > 0 && rq[m_cur])) begin
        m_last = m_cur;
        p = m_pick(rq, m_last, (m_left == 0) ? m_cur : -1);
        if (p >= 0) begin
          m_cur = p; m_left = eff_w(w, p);
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  logic [N-1:0]    ptr_tmp;
  logic [N-1:0]    rq;
  logic [N-1:0]    exp_tkn;
  logic [N*CW-1:0] rwt;
  logic            ra, rs;

  initial begin
    reset = 1'b1; req = '0; tkn_ack = 1'b0; weight = mkwt(1, 1);
    step();
    step();
    check("rst_tkn", 64'(tkn), 64'(0));
    check("rst_id", 64'(tkn_id), 64'(0));
    check("rst_vld", 64'(tkn_vld), 64'(0));
    check("rst_pe", 64'(pe), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(IDLE));

    // equal weights, 0 and 2 alternate
    cur_wt = mkwt(1, 1);
    add(1, 6'b000000, 0, 6'b000000);
    add(0, 6'b000101, 0, 6'b000001);
    add(0, 6'b000101, 1, 6'b000100);
    add(0, 6'b000101, 1, 6'b000001);
    add(0, 6'b000101, 1, 6'b000100);
    add(0, 6'b000101, 1, 6'b000001);
    // weight 3 on requester 0: bursts of three
    cur_wt = mkwt(3, 1);
    add(1, 6'b000000, 0, 6'b000000);
    add(0, 6'b000101, 0, 6'b000001);
    add(0, 6'b000101, 1, 6'b000001);
    add(0, 6'b000101, 1, 6'b000001);
    add(0, 6'b000101, 1, 6'b000100);
    add(0, 6'b000101, 1, 6'b000001);
    add(0, 6'b000101, 1, 6'b000001);
    add(0, 6'b000101, 1, 6'b000001);
    add(0, 6'b000101, 1, 6'b000100);
    // wrap-around after index 5
    cur_wt = mkwt(1, 1);
    add(1, 6'b000000, 0, 6'b000000);
    add(0, 6'b100000, 0, 6'b100000);
    add(0, 6'b100001, 1, 6'b000001);
    add(0, 6'b100001, 1, 6'b100000);
    add(0, 6'b100001, 0, 6'b100000);
    // reset mid-grant, pointer restarts
    add(1, 6'b000000, 0, 6'b000000);
    add(0, 6'b000010, 0, 6'b000010);
    add(0, 6'b000010, 0, 6'b000010);
    add(1, 6'b000110, 0, 6'b000000);
    add(0, 6'b000110, 0, 6'b000010);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; req = vecs[i].req; tkn_ack = vecs[i].ack; weight = vecs[i].wt;
      step();
      check($sformatf("vec%0d_tkn", i), 64'(tkn), 64'(vecs[i].exp_tkn));
      check($sformatf("vec%0d_vld", i), 64'(tkn_vld), 64'(|vecs[i].exp_tkn));
    end

    // single requester 3 with weight 0, re-granted after each ack
    reset = 1'b1; req = '0; tkn_ack = 1'b0;
    weight = mkwt(1, 1);
    weight[3*CW +: CW] = '0;
    step();
    reset = 1'b0; req = 6'b001000;
    step();
    check("single_first", 64'(tkn), 64'(6'b001000));
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check("single_hold", 64'(tkn), 64'(6'b001000));
      end
      tkn_ack = 1'b1;
      step();
      check("single_gap", 64'(tkn), 64'(0));
      tkn_ack = 1'b0;
      step();
      check("single_regrant", 64'(tkn), 64'(6'b001000));
    end
    req = '0; tkn_ack = 1'b1;
    step();
    check("single_drop_tkn", 64'(tkn), 64'(0));
    check("single_drop_state", 64'(fsm_state), 64'(IDLE));
    tkn_ack = 1'b0;
    step();
    check("single_idle", 64'(tkn), 64'(0));

    // parity fault on the pointer register
    reset = 1'b1; weight = mkwt(1, 1);
    step();
    reset = 1'b0; req = 6'b000101;
    step();
    check("par_pre_pe", 64'(pe), 64'(0));
    ptr_tmp = dut.pointer_reg ^ 6'b100000;
    force dut.pointer_reg = ptr_tmp;
    step();
    check("par_pe_set", 64'(pe), 64'(1));
    release dut.pointer_reg;
    tkn_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("par_pe_sticky", 64'(pe), 64'(1));
      check("par_arb_runs", 64'(tkn_vld), 64'(1));
    end
    reset = 1'b1; tkn_ack = 1'b0;
    step();
    check("par_pe_clear", 64'(pe), 64'(0));

    // randomized run against the model
    reset = 1'b1; req = '0; tkn_ack = 1'b0;
    step();
    m_busy = 0; m_last = -1; m_cur = 0; m_left = 0;
    rwt = mkwt(1, 1);
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) begin
        for (int i = 0; i < N; i++) rwt[i*CW +: CW] = CW'($urandom_range(0, 4));
      end
      rq = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 1) == 0) rq = rq & N'($urandom_range(0, (1 << N) - 1));
      if (m_busy != 0) rq[m_cur] = 1'b1;
      ra = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 299) == 0);
      reset = rs; req = rq; tkn_ack = ra; weight = rwt;
      step();
      model_step(rs, rq, ra, rwt);
      exp_tkn = (m_busy != 0) ? (N'(1) << m_cur) : '0;
      check("rnd_tkn", 64'(tkn), 64'(exp_tkn));
      check("rnd_state", 64'(fsm_state), 64'(m_busy));
      if (m_busy != 0) check("rnd_id", 64'(tkn_id), 64'(m_cur));
      check("rnd_pe", 64'(pe), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
